// File: rtl/pls_tx_byte.sv
// 10BASE-T transmit PLS, byte-wide front end.
// Manchester-encodes accepted bytes LSB first, closes every frame with an ETD
// and a stretch of enforced silence, and emits normal link pulses while idle.
// Frames also end on an underrun (no byte offered when one was due) or when
// the jabber byte limit is reached.

module pls_tx_byte #(
    parameter int HALF_BIT_CLKS = 1,
    parameter int NLP_PERIOD    = 320000,
    parameter int NLP_WIDTH     = 2,
    parameter int ETD_HALF_BITS = 12,
    parameter int SILENCE_CLKS  = 48,
    parameter int JABBER_BYTES  = 1536,
    parameter int CNT_W         = 20
) (
    input  logic       clk_20mhz,
    input  logic       rst_i,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       link_enable,
    output logic       txd_out_p,
    output logic       txd_out_n,
    output logic       txbusy,
    output logic       underrun,
    output logic       jabber
);

    localparam int HC_W = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
    localparam int BC_W = $clog2(JABBER_BYTES + 1);

    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HALF_BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] NLP_LAST = CNT_W'(NLP_PERIOD - 1);
    localparam logic [CNT_W-1:0] NLP_HIGH = CNT_W'(NLP_WIDTH);
    localparam logic [CNT_W-1:0] ETD_LAST = CNT_W'(ETD_HALF_BITS * HALF_BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] SIL_LAST = CNT_W'(SILENCE_CLKS - 1);
    localparam logic [BC_W-1:0]  JAB_MAX  = BC_W'(JABBER_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA    = 3'd1,
        ST_ETD     = 3'd2,
        ST_SILENCE = 3'd3
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic [HC_W-1:0]  half_clk, half_clk_nx;
    logic [3:0]       half_idx, half_idx_nx, idx_inc;
    logic [7:0]       cur_byte, cur_byte_nx;
    logic             cur_last, cur_last_nx;
    logic [BC_W-1:0]  byte_cnt, byte_cnt_nx;
    logic             p_nx, n_nx, busy_nx, underrun_nx, jabber_nx;
    logic             byte_end, accept, next_bit;

    assign cnt_inc  = cnt + 1'b1;
    assign idx_inc  = half_idx + 4'd1;
    assign next_bit = cur_byte[idx_inc[3:1]];
    assign byte_end = (half_idx == 4'd15) && (half_clk == HC_LAST);
    assign accept   = tx_valid && tx_ready;

    // Ready depends only on state and counters; in IDLE the p line is high
    // only during a link pulse, so it doubles as the pulse-in-progress flag.
    always_comb begin
        tx_ready = 1'b0;
        case (state)
            ST_IDLE: tx_ready = !txd_out_p;
            ST_DATA: tx_ready = byte_end && !cur_last && (byte_cnt < JAB_MAX);
            default: tx_ready = 1'b0;
        endcase
    end

    // Next state, next counters and the next value of every registered output.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        half_clk_nx = half_clk;
        half_idx_nx = half_idx;
        cur_byte_nx = cur_byte;
        cur_last_nx = cur_last;
        byte_cnt_nx = byte_cnt;
        p_nx        = 1'b0;
        n_nx        = 1'b0;
        underrun_nx = 1'b0;
        jabber_nx   = jabber;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx    = ST_DATA;
                    cnt_nx      = '0;
                    half_clk_nx = '0;
                    half_idx_nx = '0;
                    cur_byte_nx = tx_data;
                    cur_last_nx = tx_last;
                    byte_cnt_nx = BC_W'(1);
                    jabber_nx   = 1'b0;
                    p_nx        = !tx_data[0];
                    n_nx        = tx_data[0];
                end else if (!link_enable) begin
                    cnt_nx = '0;
                end else if (cnt == NLP_LAST) begin
                    cnt_nx = '0;
                    p_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt_inc;
                    p_nx   = txd_out_p && (cnt_inc < NLP_HIGH);
                end
            end
            ST_DATA: begin
                if (half_clk != HC_LAST) begin
                    half_clk_nx = half_clk + 1'b1;
                    p_nx        = txd_out_p;
                    n_nx        = txd_out_n;
                end else if (!byte_end) begin
                    half_clk_nx = '0;
                    half_idx_nx = idx_inc;
                    p_nx        = idx_inc[0] ? next_bit : !next_bit;
                    n_nx        = idx_inc[0] ? !next_bit : next_bit;
                end else if (accept) begin
                    half_clk_nx = '0;
                    half_idx_nx = '0;
                    cur_byte_nx = tx_data;
                    cur_last_nx = tx_last;
                    byte_cnt_nx = byte_cnt + 1'b1;
                    p_nx        = !tx_data[0];
                    n_nx        = tx_data[0];
                end else begin
                    state_nx = ST_ETD;
                    cnt_nx   = '0;
                    p_nx     = 1'b1;
                    if (!cur_last) begin
                        if (byte_cnt >= JAB_MAX) begin
                            jabber_nx = 1'b1;
                        end else begin
                            underrun_nx = 1'b1;
                        end
                    end
                end
            end
            ST_ETD: begin
                if (cnt == ETD_LAST) begin
                    state_nx = ST_SILENCE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_inc;
                    p_nx   = 1'b1;
                end
            end
            ST_SILENCE: begin
                if (cnt == SIL_LAST) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            default: begin
                state_nx    = ST_IDLE;
                cnt_nx      = '0;
                half_clk_nx = '0;
                half_idx_nx = '0;
            end
        endcase
        busy_nx = (state_nx == ST_DATA) || (state_nx == ST_ETD) || (state_nx == ST_SILENCE);
    end

    // State, counters and registered line outputs; reset drops the line at once.
    always_ff @(posedge clk_20mhz or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            half_clk  <= '0;
            half_idx  <= '0;
            cur_byte  <= '0;
            cur_last  <= 1'b0;
            byte_cnt  <= '0;
            txd_out_p <= 1'b0;
            txd_out_n <= 1'b0;
            txbusy    <= 1'b0;
            underrun  <= 1'b0;
            jabber    <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            half_clk  <= half_clk_nx;
            half_idx  <= half_idx_nx;
            cur_byte  <= cur_byte_nx;
            cur_last  <= cur_last_nx;
            byte_cnt  <= byte_cnt_nx;
            txd_out_p <= p_nx;
            txd_out_n <= n_nx;
            txbusy    <= busy_nx;
            underrun  <= underrun_nx;
            jabber    <= jabber_nx;
        end
    end

endmodule

// File: tb/tb_pls_tx_byte.sv
// Self-checking bench for pls_tx_byte.
// A waveform-level model turns each accepted byte into its line sequence and
// each frame end into ETD plus silence; idle link pulses are predicted from
// the length of the current link-enabled idle run. Directed sections pin the
// model with hand-computed literal expectations.

module tb_pls_tx_byte;

    localparam int H      = 1;
    localparam int NLP_P  = 100;
    localparam int NLP_W  = 2;
    localparam int ETD_HB = 12;
    localparam int SIL    = 48;
    localparam int JAB    = 4;
    localparam int CW     = 20;

    logic       clk_20mhz   = 1'b0;
    logic       rst_i       = 1'b1;
    logic [7:0] tx_data     = 8'h00;
    logic       tx_valid    = 1'b0;
    logic       tx_last     = 1'b0;
    logic       link_enable = 1'b0;
    logic       tx_ready, txd_out_p, txd_out_n, txbusy, underrun, jabber;

    int checks = 0;
    int errors = 0;

    always #25 clk_20mhz = ~clk_20mhz;

    pls_tx_byte #(
        .HALF_BIT_CLKS(H),
        .NLP_PERIOD(NLP_P),
        .NLP_WIDTH(NLP_W),
        .ETD_HALF_BITS(ETD_HB),
        .SILENCE_CLKS(SIL),
        .JABBER_BYTES(JAB),
        .CNT_W(CW)
    ) dut (
        .clk_20mhz(clk_20mhz),
        .rst_i(rst_i),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_last(tx_last),
        .tx_ready(tx_ready),
        .link_enable(link_enable),
        .txd_out_p(txd_out_p),
        .txd_out_n(txd_out_n),
        .txbusy(txbusy),
        .underrun(underrun),
        .jabber(jabber)
    );

    // ---------------- expected-waveform model ----------------
    typedef struct packed {
        logic p;
        logic n;
        logic rdy;
        logic endb;
        logic ur;
    } ent_t;

    ent_t exp_q[$];
    int   en_run  = 0;
    int   m_bytes = 0;
    logic m_last  = 1'b0;
    logic exp_jab = 1'b0;
    ent_t f;
    logic acc;
    logic ep;

    function automatic logic nlp_due(input int run);
        return (run >= NLP_P) && ((run % NLP_P) < NLP_W);
    endfunction

    function automatic void model_byte(input logic [7:0] d, input logic is_last, input int n_bytes);
        ent_t e;
        for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < H; c++) begin
                e.p    = (b % 2 == 0) ? !d[b/2] : d[b/2];
                e.n    = !e.p;
                e.endb = (b == 15) && (c == H - 1);
                e.rdy  = e.endb && !is_last && (n_bytes < JAB);
                e.ur   = 1'b0;
                exp_q.push_back(e);
            end
        end
    endfunction

    function automatic void model_tail(input logic ur);
        ent_t e;
        for (int i = 0; i < ETD_HB * H; i++) begin
            e.p = 1'b1; e.n = 1'b0; e.rdy = 1'b0; e.endb = 1'b0;
            e.ur = ur && (i == 0);
            exp_q.push_back(e);
        end
        for (int i = 0; i < SIL; i++) begin
            e = '0;
            exp_q.push_back(e);
        end
    endfunction

    // Advance the model by one clock using the inputs the DUT samples.
    always @(posedge clk_20mhz or posedge rst_i) begin
        if (rst_i) begin
            exp_q.delete();
            en_run  = 0;
            m_bytes = 0;
            m_last  = 1'b0;
            exp_jab = 1'b0;
        end else if (exp_q.size() != 0) begin
            f   = exp_q.pop_front();
            acc = tx_valid && f.rdy;
            if (f.endb) begin
                if (acc) begin
                    m_bytes++;
                    m_last = tx_last;
                    model_byte(tx_data, tx_last, m_bytes);
                end else begin
                    model_tail(!m_last && (m_bytes < JAB));
                    if (!m_last && (m_bytes >= JAB)) exp_jab = 1'b1;
                end
            end
            if (exp_q.size() == 0) en_run = 0;
        end else if (tx_valid && !nlp_due(en_run)) begin
            m_bytes = 1;
            m_last  = tx_last;
            exp_jab = 1'b0;
            model_byte(tx_data, tx_last, 1);
        end else begin
            en_run = link_enable ? en_run + 1 : 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk_20mhz) begin
        if (!rst_i) begin
            if (exp_q.size() != 0) begin
                checkOutput("line_p", txd_out_p, exp_q[0].p);
                checkOutput("line_n", txd_out_n, exp_q[0].n);
                checkOutput("busy", txbusy, 1'b1);
                checkOutput("ready", tx_ready, exp_q[0].rdy);
                checkOutput("underrun", underrun, exp_q[0].ur);
            end else begin
                ep = nlp_due(en_run);
                checkOutput("idle_p", txd_out_p, ep);
                checkOutput("idle_n", txd_out_n, 1'b0);
                checkOutput("idle_busy", txbusy, 1'b0);
                checkOutput("idle_ready", tx_ready, !ep);
                checkOutput("idle_underrun", underrun, 1'b0);
            end
            checkOutput("jabber", jabber, exp_jab);
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic [7:0] d, input logic v, input logic l);
        tx_data  = d;
        tx_valid = v;
        tx_last  = l;
    endtask

    // Offer a byte at a falling edge and return at the falling edge after acceptance.
    task automatic push_byte(input logic [7:0] d, input logic l);
        int guard = 0;
        applyStimulus(d, 1'b1, l);
        while (!tx_ready && guard < 300) begin
            @(negedge clk_20mhz);
            guard++;
        end
        checkOutput("push_ready", tx_ready, 1'b1);
        @(negedge clk_20mhz);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (txbusy && guard < 400) begin
            @(negedge clk_20mhz);
            guard++;
        end
        checkOutput("idle_reached", txbusy, 1'b0);
    endtask

    // Single 0xA5 frame with literal line sequence and frame length.
    task automatic check_a5(input string tag);
        logic [15:0] seq = '0;
        int busy_cnt = 0, etd_high = 0, nbad = 0;
        push_byte(8'hA5, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (i < 16) begin
                seq = {seq[14:0], txd_out_p};
                if (txd_out_n !== ~txd_out_p) nbad++;
            end
            if (txbusy) busy_cnt++;
            if (i >= 16 && i < 76 && txd_out_p) etd_high++;
            @(negedge clk_20mhz);
        end
        checkOutput({tag, "_p_seq"}, seq, 16'h6699);
        checkOutput({tag, "_n_complement"}, nbad, 0);
        checkOutput({tag, "_busy_clks"}, busy_cnt, 76);
        checkOutput({tag, "_etd_high"}, etd_high, 12);
    endtask

    initial begin
        logic [31:0] seq32;
        int rdy_cnt, rdy_pos, ur_cnt, ur_pos, jab_seen, rises, first_rise, high_cnt, n_high, rdy_pulse, hs;
        logic prev_p, bump;

        // reset state
        repeat (3) @(negedge clk_20mhz);
        checkOutput("rst_p", txd_out_p, 1'b0);
        checkOutput("rst_n", txd_out_n, 1'b0);
        checkOutput("rst_busy", txbusy, 1'b0);
        checkOutput("rst_underrun", underrun, 1'b0);
        checkOutput("rst_jabber", jabber, 1'b0);
        #2 rst_i = 1'b0;
        @(negedge clk_20mhz);
        checkOutput("ready_after_reset", tx_ready, 1'b1);

        // single byte
        check_a5("a5");

        // back-to-back 0x00, 0xFF(last)
        push_byte(8'h00, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b1);
        seq32 = '0; rdy_cnt = 0; rdy_pos = -1;
        for (int i = 0; i < 32; i++) begin
            if (i == 16) applyStimulus(8'h00, 1'b0, 1'b0);
            seq32 = {seq32[30:0], txd_out_p};
            if (tx_ready) begin rdy_cnt++; rdy_pos = i; end
            @(negedge clk_20mhz);
        end
        checkOutput("b2b_p_seq", seq32, 32'hAAAA5555);
        checkOutput("b2b_ready_cnt", rdy_cnt, 1);
        checkOutput("b2b_ready_pos", rdy_pos, 15);
        wait_idle();

        // underrun
        push_byte(8'h55, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        ur_cnt = 0; ur_pos = -1; jab_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (underrun) begin ur_cnt++; ur_pos = i; end
            if (jabber) jab_seen++;
            @(negedge clk_20mhz);
        end
        checkOutput("ur_pulses", ur_cnt, 1);
        checkOutput("ur_pos", ur_pos, 16);
        checkOutput("ur_jabber", jab_seen, 0);
        wait_idle();

        // link pulses enabled, then disabled
        link_enable = 1'b1;
        rises = 0; first_rise = -1; high_cnt = 0; n_high = 0; rdy_pulse = 0; prev_p = 1'b0;
        for (int i = 0; i < 250; i++) begin
            if (txd_out_p && !prev_p) begin
                rises++;
                if (first_rise < 0) first_rise = i;
            end
            if (txd_out_p) high_cnt++;
            if (txd_out_n) n_high++;
            if (txd_out_p && tx_ready) rdy_pulse++;
            prev_p = txd_out_p;
            @(negedge clk_20mhz);
        end
        checkOutput("nlp_rises", rises, 2);
        checkOutput("nlp_first", first_rise, 100);
        checkOutput("nlp_high_clks", high_cnt, 4);
        checkOutput("nlp_n_high", n_high, 0);
        checkOutput("nlp_ready_in_pulse", rdy_pulse, 0);
        link_enable = 1'b0;
        high_cnt = 0;
        for (int i = 0; i < 250; i++) begin
            if (txd_out_p) high_cnt++;
            @(negedge clk_20mhz);
        end
        checkOutput("nlp_disabled", high_cnt, 0);

        // jabber: continuous valid without last
        applyStimulus(8'h11, 1'b1, 1'b0);
        hs = 0; ur_cnt = 0; bump = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bump) begin tx_data = tx_data + 8'h11; bump = 1'b0; end
            if (i == 70) applyStimulus(8'h00, 1'b0, 1'b0);
            if (tx_valid && tx_ready) begin hs++; bump = 1'b1; end
            if (underrun) ur_cnt++;
            @(negedge clk_20mhz);
        end
        checkOutput("jab_bytes", hs, 4);
        checkOutput("jab_set", jabber, 1'b1);
        checkOutput("jab_no_underrun", ur_cnt, 0);
        wait_idle();
        repeat (5) @(negedge clk_20mhz);
        checkOutput("jab_sticky_idle", jabber, 1'b1);
        push_byte(8'h3C, 1'b1);
        checkOutput("jab_cleared", jabber, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        wait_idle();

        // reset in the middle of the third byte
        push_byte(8'h01, 1'b0);
        push_byte(8'h02, 1'b0);
        push_byte(8'h03, 1'b0);
        repeat (4) @(negedge clk_20mhz);
        #2;
        rst_i = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0);
        #1;
        checkOutput("midrst_p", txd_out_p, 1'b0);
        checkOutput("midrst_n", txd_out_n, 1'b0);
        checkOutput("midrst_busy", txbusy, 1'b0);
        repeat (2) @(negedge clk_20mhz);
        #2 rst_i = 1'b0;
        #1 checkOutput("midrst_ready", tx_ready, 1'b1);
        @(negedge clk_20mhz);
        check_a5("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
